// File: rtl/sobel_window_ctrl_if.sv
// Handshake bundle between the Sobel window sequencer and its FIFOs/datapath.
// master = sequencer side, slave = FIFO/datapath side.
interface sobel_window_ctrl_if;
    logic        in_empty;
    logic        in_rd_en;
    logic        shift_en;
    logic        flush_pad;
    logic        out_afull;
    logic        out_wr_en;
    logic        border;
    logic [10:0] row;
    logic [10:0] col;
    logic        frame_done;
    logic [31:0] stall_cycles;

    modport master (
        input  in_empty, out_afull,
        output in_rd_en, shift_en, flush_pad, out_wr_en, border, row, col,
               frame_done, stall_cycles
    );

    modport slave (
        output in_empty, out_afull,
        input  in_rd_en, shift_en, flush_pad, out_wr_en, border, row, col,
               frame_done, stall_cycles
    );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Sequencer for the 3x3 Sobel window: pops pixels, shifts the window, flushes with zero pads.
// Optional macro SOBEL_WINDOW_CTRL_STATS_EN builds the output-backpressure stall counter.
module sobel_window_ctrl #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540
) (
    input  logic                 clock,
    input  logic                 reset,
    sobel_window_ctrl_if.master  bus
);
    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(NPIX + IMG_WIDTH + 2);

    localparam logic [CNT_W-1:0] LAST_POP   = CNT_W'(NPIX - 1);
    // shift_cnt values seen before the shift that completes the first / last full window
    localparam logic [CNT_W-1:0] FIRST_WR_K = CNT_W'(IMG_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_PAD_K = CNT_W'(NPIX + IMG_WIDTH);
    localparam logic [10:0]      LAST_COL   = 11'(IMG_WIDTH - 1);
    localparam logic [10:0]      LAST_ROW   = 11'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] shift_cnt;
    logic             shift;
    logic             pop;
    logic             write_next;
    logic [10:0]      row_next;
    logic [10:0]      col_next;
    logic             border_next;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        shift      = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.in_empty) state_next = RUN;
            end
            RUN: begin
                shift = !bus.in_empty && !bus.out_afull;
                pop   = shift;
                if (pop && in_cnt == LAST_POP) state_next = FLUSH;
            end
            FLUSH: begin
                // Pending pixels for the next frame stay in the FIFO until IDLE.
                shift = !bus.out_afull;
                if (shift && shift_cnt == LAST_PAD_K) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            shift = 1'b0;
            pop   = 1'b0;
        end
    end

    // A shift produces a result once the window centre has reached a real pixel.
    always_comb begin
        write_next = shift && (shift_cnt >= FIRST_WR_K) && (shift_cnt <= LAST_PAD_K);
        row_next   = bus.row;
        col_next   = bus.col;
        if (shift_cnt == FIRST_WR_K) begin
            row_next = '0;
            col_next = '0;
        end else if (bus.col == LAST_COL) begin
            row_next = bus.row + 11'd1;
            col_next = '0;
        end else begin
            col_next = bus.col + 11'd1;
        end
        border_next = (row_next == '0) || (row_next == LAST_ROW) ||
                      (col_next == '0) || (col_next == LAST_COL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_cnt         <= '0;
            shift_cnt      <= '0;
            bus.out_wr_en  <= 1'b0;
            bus.border     <= 1'b0;
            bus.row        <= '0;
            bus.col        <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= (state == DONE);
            bus.out_wr_en  <= write_next;
            bus.border     <= write_next && border_next;
            if (state == DONE) begin
                in_cnt    <= '0;
                shift_cnt <= '0;
                bus.row   <= '0;
                bus.col   <= '0;
            end else begin
                if (pop)   in_cnt    <= in_cnt + 1'b1;
                if (shift) shift_cnt <= shift_cnt + 1'b1;
                if (write_next) begin
                    bus.row <= row_next;
                    bus.col <= col_next;
                end
            end
        end
    end

    assign bus.shift_en  = shift;
    assign bus.in_rd_en  = pop;
    assign bus.flush_pad = (state == FLUSH) && !reset;

`ifdef SOBEL_WINDOW_CTRL_STATS_EN
    // Saturating count of cycles the output FIFO held back an active frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.stall_cycles <= '0;
        end else if ((state == RUN || state == FLUSH) && bus.out_afull &&
                     bus.stall_cycles != 32'hFFFF_FFFF) begin
            bus.stall_cycles <= bus.stall_cycles + 32'd1;
        end
    end
`else
    assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 4x3 frame.
module tb_sobel_window_ctrl;
    localparam int W = 4;
    localparam int H = 3;
    // bit i = border flag of pixel i in raster order
    localparam bit [11:0] BORDER_MAP = 12'b1111_1001_1111;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sobel_window_ctrl_if bus ();

    sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int cyc, n_shift, n_pop, n_pad, n_wr, n_done;
    int n_shift_afull, n_pop_empty, n_wr_afull, n_border_stray;
    int cyc_6th, cyc_first_wr, cyc_last_wr, cyc_done;
    logic [10:0] wr_row [16];
    logic [10:0] wr_col [16];
    logic        wr_border [16];

    always @(negedge clock) begin
        cyc++;
        if (bus.shift_en) begin
            n_shift++;
            if (n_shift == 6) cyc_6th = cyc;
            if (bus.flush_pad) n_pad++;
            if (bus.out_afull) n_shift_afull++;
        end
        if (bus.in_rd_en) begin
            n_pop++;
            if (bus.in_empty) n_pop_empty++;
        end
        if (bus.out_wr_en) begin
            if (n_wr < 16) begin
                wr_row[n_wr]    = bus.row;
                wr_col[n_wr]    = bus.col;
                wr_border[n_wr] = bus.border;
            end
            if (n_wr == 0) cyc_first_wr = cyc;
            cyc_last_wr = cyc;
            n_wr++;
            if (bus.out_afull) n_wr_afull++;
        end else if (bus.border) begin
            n_border_stray++;
        end
        if (bus.frame_done) begin
            n_done++;
            cyc_done = cyc;
        end
    end

    task automatic clear_logs();
        cyc = 0; n_shift = 0; n_pop = 0; n_pad = 0; n_wr = 0; n_done = 0;
        n_shift_afull = 0; n_pop_empty = 0; n_wr_afull = 0; n_border_stray = 0;
        cyc_6th = -1; cyc_first_wr = -1; cyc_last_wr = -1; cyc_done = -1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.in_empty = 1'b1;
        bus.out_afull = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clear_logs();
    endtask

    // Feeds one 12-pixel frame; optional out_afull window, starvation, early stop after stop_pops pops.
    task automatic drive_frame(input int afull_start, input int afull_len,
                               input bit starve, input int stop_pops);
        int t = 0;
        bus.in_empty = 1'b0;
        bus.out_afull = 1'b0;
        while (n_done == 0 && t < 200 && !(stop_pops > 0 && n_pop >= stop_pops)) begin
            @(posedge clock);
            #1;
            bus.in_empty  = (n_pop >= W * H) || (starve && t[0]);
            bus.out_afull = (t >= afull_start) && (t < afull_start + afull_len);
            t++;
        end
        bus.out_afull = 1'b0;
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL frame_timeout: stopped after %0d cycles, pops=%0d writes=%0d", t, n_pop, n_wr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_empty = 1'b0;
        bus.out_afull = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({bus.in_rd_en, bus.shift_en, bus.flush_pad, bus.out_wr_en, bus.border, bus.frame_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {bus.in_rd_en, bus.shift_en, bus.flush_pad, bus.out_wr_en, bus.border, bus.frame_done});
        end
        checks++;
        if ({bus.row, bus.col} !== 22'd0) begin
            errors++;
            $display("FAIL reset_rowcol: got row=%0d col=%0d required 0 0", bus.row, bus.col);
        end
        checks++;
        if (bus.stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d required 0", bus.stall_cycles);
        end
        apply_reset();
    endtask

    task automatic test_free_flow();
        int idle_shift;
        apply_reset();
        drive_frame(1000, 0, 1'b0, 0);
        checks++;
        if (n_pop !== 12) begin errors++; $display("FAIL ff_pops: got %0d required 12", n_pop); end
        checks++;
        if (n_wr !== 12) begin errors++; $display("FAIL ff_writes: got %0d required 12", n_wr); end
        checks++;
        if (n_pad !== 5) begin errors++; $display("FAIL ff_pads: got %0d required 5", n_pad); end
        checks++;
        if (n_shift !== 17) begin errors++; $display("FAIL ff_shifts: got %0d required 17", n_shift); end
        checks++;
        if (cyc_first_wr !== cyc_6th + 1) begin
            errors++;
            $display("FAIL ff_first_latency: first write cycle %0d, required %0d", cyc_first_wr, cyc_6th + 1);
        end
        checks++;
        if (cyc_done !== cyc_last_wr + 1) begin
            errors++;
            $display("FAIL ff_done_timing: frame_done cycle %0d, required %0d", cyc_done, cyc_last_wr + 1);
        end
        bus.in_empty = 1'b1;
        idle_shift = n_shift;
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (n_shift !== idle_shift || n_done !== 1) begin
            errors++;
            $display("FAIL ff_idle_after: shifts %0d->%0d done=%0d, required no shift and done=1",
                     idle_shift, n_shift, n_done);
        end
        checks++;
        if ({bus.row, bus.col} !== 22'd0) begin
            errors++;
            $display("FAIL ff_rowcol_cleared: got row=%0d col=%0d required 0 0", bus.row, bus.col);
        end
    endtask

    task automatic test_border();
        bit [11:0] map;
        map = BORDER_MAP;
        apply_reset();
        drive_frame(1000, 0, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({wr_row[i], wr_col[i], wr_border[i]} !== {11'(i / W), 11'(i % W), map[i]}) begin
                errors++;
                $display("FAIL border_write%0d: got (%0d,%0d,b=%0b) required (%0d,%0d,b=%0b)",
                         i, wr_row[i], wr_col[i], wr_border[i], i / W, i % W, map[i]);
            end
        end
        checks++;
        if (n_border_stray !== 0) begin
            errors++;
            $display("FAIL border_unqualified: border high without write %0d times, required 0", n_border_stray);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive_frame(4, 10, 1'b0, 0);
        checks++;
        if (n_shift_afull !== 0) begin
            errors++;
            $display("FAIL bp_shift_during_afull: got %0d shifts required 0", n_shift_afull);
        end
        checks++;
        if (n_wr_afull > 1) begin
            errors++;
            $display("FAIL bp_trailing_writes: got %0d required <=1", n_wr_afull);
        end
        checks++;
        if (n_wr !== 12 || n_done !== 1) begin
            errors++;
            $display("FAIL bp_writes: got writes=%0d done=%0d required 12 and 1", n_wr, n_done);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({wr_row[i], wr_col[i]} !== {11'(i / W), 11'(i % W)}) begin
                errors++;
                $display("FAIL bp_order%0d: got (%0d,%0d) required (%0d,%0d)",
                         i, wr_row[i], wr_col[i], i / W, i % W);
            end
        end
        checks++;
`ifdef SOBEL_WINDOW_CTRL_STATS_EN
        if (bus.stall_cycles !== 32'd10) begin
            errors++;
            $display("FAIL bp_stall_cycles: got %0d required 10", bus.stall_cycles);
        end
`else
        if (bus.stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL bp_stall_cycles: got %0d required 0", bus.stall_cycles);
        end
`endif
    endtask

    task automatic test_starvation();
        apply_reset();
        drive_frame(1000, 0, 1'b1, 0);
        checks++;
        if (n_pop_empty !== 0) begin
            errors++;
            $display("FAIL starve_pop_empty: got %0d pops while empty required 0", n_pop_empty);
        end
        checks++;
        if (n_pop !== 12 || n_wr !== 12) begin
            errors++;
            $display("FAIL starve_counts: got pops=%0d writes=%0d required 12 12", n_pop, n_wr);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if ({wr_row[i], wr_col[i]} !== {11'(i / W), 11'(i % W)}) begin
                errors++;
                $display("FAIL starve_order%0d: got (%0d,%0d) required (%0d,%0d)",
                         i, wr_row[i], wr_col[i], i / W, i % W);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        drive_frame(1000, 0, 1'b0, 7);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({bus.in_rd_en, bus.shift_en, bus.flush_pad, bus.out_wr_en, bus.border,
             bus.frame_done, bus.row, bus.col} !== 28'd0) begin
            errors++;
            $display("FAIL midreset_outputs: wr=%b row=%0d col=%0d shift=%b, required all 0",
                     bus.out_wr_en, bus.row, bus.col, bus.shift_en);
        end
        reset = 1'b0;
        clear_logs();
        drive_frame(1000, 0, 1'b0, 0);
        checks++;
        if (n_wr !== 12 || n_done !== 1) begin
            errors++;
            $display("FAIL midreset_writes: got writes=%0d done=%0d required 12 and 1", n_wr, n_done);
        end
        checks++;
        if ({wr_row[0], wr_col[0]} !== 22'd0) begin
            errors++;
            $display("FAIL midreset_first: got (%0d,%0d) required (0,0)", wr_row[0], wr_col[0]);
        end
        checks++;
        if ({wr_row[11], wr_col[11]} !== {11'd2, 11'd3}) begin
            errors++;
            $display("FAIL midreset_last: got (%0d,%0d) required (2,3)", wr_row[11], wr_col[11]);
        end
    endtask

    initial begin
        bus.in_empty = 1'b1;
        bus.out_afull = 1'b0;
        clear_logs();
        test_reset();
        test_free_flow();
        test_border();
        test_backpressure();
        test_starvation();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
